uart_tx_engine: RTL

Serial transmit half of the CPU's UART path: takes bytes from the memory-mapped UART write port and shifts them out on FPGA_SERIAL_TX as 8N1 frames. It is the counterpart to the receive engine feeding UARTread/DataOutValid. It sits inside the UART wrapper, driven by the DataIn/DataInValid/DataInReady handshake that the UART address decoder produces on stores to the UART transmit address.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_counter.sv | 35 +++
 rtl/uart_tx_engine.sv | 117 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, frame geometry and baud divisor helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  function automatic int cycles_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period tick generator: counts 0..CYCLES_PER_BIT-1 while enabled, tick on the last count.
// Synchronous clear wins over enable; shared by the transmit and receive engines.
module uart_baud_counter #(
  parameter int CYCLES_PER_BIT = 434,
  localparam int CNT_W = $clog2(CYCLES_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic             o_tick,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en & w_last;
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/uart_tx_engine.sv
// 8N1 serial transmitter: start bit appears the cycle after accept, frame lasts 10*CYCLES_PER_BIT cycles.
// Registered ready reasserts in the last stop-bit cycle so held-valid producers stream with no gap.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out,
  output logic       tx_busy
);

  localparam int CYCLES_PER_BIT = cycles_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT);

  generate
    if (CYCLES_PER_BIT < 2) begin : g_cpb_check
      $error("uart_tx_engine: CLOCK_FREQ/BAUD_RATE must be at least 2");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CYCLES_PER_BIT - 2);
  localparam logic [3:0]       LAST_DATA    = 4'(DATA_BITS);

  uart_state_t           r_state;
  uart_state_t           w_state_nxt;
  logic [FRAME_BITS-1:0] r_shift;
  logic [3:0]            r_bit_idx;
  logic                  r_serial;
  logic                  r_ready;
  logic                  r_busy;

  logic                  w_accept;
  logic                  w_tick;
  logic [CNT_W-1:0]      w_cnt;
  logic                  w_serial_d;
  logic                  w_ready_d;

  assign w_accept = data_in_valid & r_ready;

  uart_baud_counter #(
    .CYCLES_PER_BIT(CYCLES_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_accept),
    .i_en  (r_state != ST_IDLE),
    .o_tick(w_tick),
    .o_cnt (w_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_START;
      ST_START: if (w_tick) w_state_nxt = ST_DATA;
      ST_DATA:  if (w_tick && r_bit_idx == LAST_DATA) w_state_nxt = ST_STOP;
      ST_STOP: begin
        if (w_accept) w_state_nxt = ST_START;
        else if (w_tick) w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // The line register takes shift[1], i.e. the LSB the shift register holds after this tick.
  always_comb begin
    w_serial_d = r_serial;
    w_ready_d  = r_ready;
    if (w_accept) begin
      w_serial_d = 1'b0;
      w_ready_d  = 1'b0;
    end else begin
      if (w_tick) w_serial_d = r_shift[1];
      if (r_state == ST_STOP && w_cnt == CNT_PRE_LAST) w_ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_serial  <= 1'b1;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_serial <= w_serial_d;
      r_ready  <= w_ready_d;
      r_busy   <= ~w_ready_d;
      if (w_accept) begin
        r_shift   <= {1'b1, data_in, 1'b0};
        r_bit_idx <= '0;
      end else if (w_tick) begin
        r_shift   <= {1'b1, r_shift[FRAME_BITS-1:1]};
        r_bit_idx <= (r_state == ST_STOP) ? 4'd0 : r_bit_idx + 4'd1;
      end
    end
  end

  assign data_in_ready = r_ready;
  assign serial_out    = r_serial;
  assign tx_busy       = r_busy;

endmodule
